// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper.
package tt_sweep_pkg;

    localparam int ROWS  = 8;
    localparam int ROW_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/tt_settle_timer.sv
// Settle-time down-counter: load sets the count, then it counts down to zero
// and holds there. expired is high whenever the count is zero.
module tt_settle_timer
    import tt_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load wins over counting; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all eight input rows of a 3-input gate, holds each row for a settle
// time, samples the gate output into an 8-bit truth-table code (row 000 lands
// in bit 7) and compares the code with a reference latched at start.
//
// Handshake: start is a request that is only looked at in IDLE; the cycle it
// is seen there is the acceptance. busy is then high for the whole sweep
// (SETTLE/SAMPLE), followed by exactly one cycle of done (DONE state, busy
// low). start during busy or during the done cycle has no effect.
module truth_table_sweeper
    import tt_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       dut_out,
    input  logic [7:0] expected,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    output logic       busy,
    output logic       done,
    output logic [7:0] code,
    output logic       match,
    output logic [1:0] dbg_state
);

    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(SETTLE_CYCLES);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);

    state_e           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [7:0]       code_q, code_d;
    logic [7:0]       exp_q, exp_d;
    logic             match_q, match_d;
    logic             timer_load;
    logic             timer_expired;

    tt_settle_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (timer_load),
        .value   (SETTLE_VAL),
        .expired (timer_expired)
    );

    // Next-state, row stepping and code capture.
    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        code_d     = code_q;
        exp_d      = exp_q;
        match_d    = match_q;
        timer_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    exp_d      = expected;
                    code_d     = '0;
                    match_d    = 1'b0;
                    row_d      = '0;
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end
            SETTLE: begin
                if (timer_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                // ~row is 7-row for a 3-bit row index.
                code_d[~row_q] = dut_out;
                if (row_q != LAST_ROW) begin
                    row_d      = row_q + ROW_W'(1);
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end else begin
                    // Compare the completed code so match is valid with done.
                    match_d = (code_d == exp_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            code_q  <= '0;
            exp_q   <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            code_q  <= code_d;
            exp_q   <= exp_d;
            match_q <= match_d;
        end
    end

    // The row register drives the gate directly; it parks at 111 after a sweep.
    assign {in1, in2, in3} = row_q;
    assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign code      = code_q;
    assign match     = match_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (settle 4, 0 and 2) driven
// by behavioural gate models. Sweep cycles are numbered from the start
// acceptance edge: the cycle that begins at that edge is cycle 1.
module tb_truth_table_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start_r[3];
  logic [7:0] exp_r[3];
  logic [1:0] gate_sel[3];
  logic       dout_w[3];
  logic       in1_w[3], in2_w[3], in3_w[3];
  logic       busy_w[3], done_w[3], match_w[3];
  logic [7:0] code_w[3];
  logic [1:0] st_w[3];

  // expected results: {match, code}
  logic [8:0] exp_q[$];
  int total = 0;
  int bad = 0;

  logic [2:0] row_seen[1:256];
  logic       match_seen[1:256];

  // gate selections: 0 NOR(in1,in2), 1 AND3, 2 constant 1, 3 XOR3
  function automatic logic gate_fn(input logic [1:0] sel, input logic [2:0] r);
    case (sel)
      2'd0:    return ~(r[2] | r[1]);
      2'd1:    return &r;
      2'd2:    return 1'b1;
      default: return ^r;
    endcase
  endfunction

  // instance 2 sees its gate through a 3-cycle output delay
  logic [2:0] dly_q = 3'b000;
  always @(posedge clk) dly_q <= {dly_q[1:0], gate_fn(gate_sel[2], {in1_w[2], in2_w[2], in3_w[2]})};

  always_comb begin
    dout_w[0] = gate_fn(gate_sel[0], {in1_w[0], in2_w[0], in3_w[0]});
    dout_w[1] = gate_fn(gate_sel[1], {in1_w[1], in2_w[1], in3_w[1]});
    dout_w[2] = dly_q[2];
  end

  truth_table_sweeper #(.SETTLE_CYCLES(4)) u_dut_s4 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .dut_out(dout_w[0]), .expected(exp_r[0]),
    .in1(in1_w[0]), .in2(in2_w[0]), .in3(in3_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .code(code_w[0]), .match(match_w[0]), .dbg_state(st_w[0]));

  truth_table_sweeper #(.SETTLE_CYCLES(0)) u_dut_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .dut_out(dout_w[1]), .expected(exp_r[1]),
    .in1(in1_w[1]), .in2(in2_w[1]), .in3(in3_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .code(code_w[1]), .match(match_w[1]), .dbg_state(st_w[1]));

  truth_table_sweeper #(.SETTLE_CYCLES(2)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .dut_out(dout_w[2]), .expected(exp_r[2]),
    .in1(in1_w[2]), .in2(in2_w[2]), .in3(in3_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .code(code_w[2]), .match(match_w[2]), .dbg_state(st_w[2]));

  // driver: one-cycle start pulse; returns #1 into sweep cycle 1
  task automatic drive_start(input int d, input logic [7:0] e, input logic [8:0] result);
    exp_q.push_back(result);
    exp_r[d] = e;
    start_r[d] = 1'b1;
    @(posedge clk);
    #1;
    start_r[d] = 1'b0;
  endtask

  // follows a sweep until done (bounded), recording rows and match per cycle;
  // optionally pulses start at cycle poke_at and/or in the done cycle
  task automatic sweep_watch(input int d, input int poke_at, input bit poke_done,
                             output int lat, output int busy_n,
                             output logic done_next, output logic busy_next);
    int c = 1;
    lat = 0;
    busy_n = 0;
    while (c <= 256) begin
      row_seen[c] = {in1_w[d], in2_w[d], in3_w[d]};
      match_seen[c] = match_w[d];
      if (busy_w[d]) busy_n++;
      if (done_w[d]) begin
        lat = c;
        break;
      end
      if (c == poke_at) begin
        start_r[d] = 1'b1;
        exp_r[d] = 8'h00;
      end
      @(posedge clk);
      #1;
      start_r[d] = 1'b0;
      c++;
    end
    if (poke_done) start_r[d] = 1'b1;
    @(posedge clk);
    #1;
    start_r[d] = 1'b0;
    done_next = done_w[d];
    busy_next = busy_w[d];
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start_r[d] = 1'b0;
      exp_r[d] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      total++;
      if ({in1_w[d], in2_w[d], in3_w[d], busy_w[d], done_w[d], match_w[d]} !== 6'b0) begin
        bad++;
        $display("FAIL reset_ctl[%0d]: got %b want 000000", d,
                 {in1_w[d], in2_w[d], in3_w[d], busy_w[d], done_w[d], match_w[d]});
      end
      total++;
      if (code_w[d] !== 8'h00) begin
        bad++;
        $display("FAIL reset_code[%0d]: got %h want 00", d, code_w[d]);
      end
      total++;
      if (st_w[d] !== 2'd0) begin
        bad++;
        $display("FAIL reset_state[%0d]: got %0d want 0", d, st_w[d]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nor;
    int lat, bn, m_bad;
    logic dn, bx;
    logic [8:0] e;
    gate_sel[0] = 2'd0;
    drive_start(0, 8'hC0, {1'b1, 8'hC0});
    sweep_watch(0, 0, 1'b0, lat, bn, dn, bx);
    e = exp_q.pop_front();
    total++;
    if (lat !== 49) begin bad++; $display("FAIL nor_latency: got %0d want 49", lat); end
    total++;
    if (code_w[0] !== e[7:0]) begin bad++; $display("FAIL nor_code: got %h want %h", code_w[0], e[7:0]); end
    total++;
    if (match_w[0] !== e[8]) begin bad++; $display("FAIL nor_match: got %b want %b", match_w[0], e[8]); end
    total++;
    if (lat > 0 && match_seen[lat] !== e[8]) begin
      bad++; $display("FAIL nor_match_at_done: got %b want %b", match_seen[lat], e[8]);
    end
    m_bad = 0;
    for (int c = 1; c < lat; c++) if (match_seen[c] !== 1'b0) m_bad++;
    total++;
    if (m_bad !== 0) begin bad++; $display("FAIL nor_match_in_sweep: got %0d high cycles want 0", m_bad); end
    total++;
    if ({dn, bx} !== 2'b00) begin bad++; $display("FAIL nor_after_done: got done,busy=%b want 00", {dn, bx}); end
    total++;
    if ({in1_w[0], in2_w[0], in3_w[0]} !== 3'b111) begin
      bad++; $display("FAIL nor_park_row: got %b want 111", {in1_w[0], in2_w[0], in3_w[0]});
    end
  endtask

  task automatic test_and3_rows;
    int lat, bn, m_bad;
    logic dn, bx;
    logic [8:0] e;
    gate_sel[0] = 2'd1;
    drive_start(0, 8'hC0, {1'b0, 8'h01});
    sweep_watch(0, 0, 1'b0, lat, bn, dn, bx);
    e = exp_q.pop_front();
    total++;
    if (lat !== 49) begin bad++; $display("FAIL and3_latency: got %0d want 49", lat); end
    total++;
    if (code_w[0] !== e[7:0]) begin bad++; $display("FAIL and3_code: got %h want %h", code_w[0], e[7:0]); end
    total++;
    if (match_w[0] !== e[8]) begin bad++; $display("FAIL and3_match: got %b want %b", match_w[0], e[8]); end
    m_bad = 0;
    for (int c = 1; c <= 48; c++) if (row_seen[c] !== 3'((c - 1) / 6)) m_bad++;
    total++;
    if (m_bad !== 0) begin bad++; $display("FAIL and3_row_steps: got %0d wrong cycles want 0", m_bad); end
  endtask

  task automatic test_const1_s0;
    int lat, bn;
    logic dn, bx;
    logic [8:0] e;
    gate_sel[1] = 2'd2;
    drive_start(1, 8'hFF, {1'b1, 8'hFF});
    sweep_watch(1, 0, 1'b0, lat, bn, dn, bx);
    e = exp_q.pop_front();
    total++;
    if (lat !== 17) begin bad++; $display("FAIL s0_latency: got %0d want 17", lat); end
    total++;
    if (bn !== 16) begin bad++; $display("FAIL s0_busy_cycles: got %0d want 16", bn); end
    total++;
    if ({match_w[1], code_w[1]} !== e) begin
      bad++; $display("FAIL s0_result: got %h want %h", {match_w[1], code_w[1]}, e);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bn, extra;
    logic dn, bx;
    logic [8:0] e;
    gate_sel[0] = 2'd0;
    drive_start(0, 8'hC0, {1'b1, 8'hC0});
    sweep_watch(0, 10, 1'b1, lat, bn, dn, bx);
    e = exp_q.pop_front();
    total++;
    if (lat !== 49) begin bad++; $display("FAIL ign_latency: got %0d want 49", lat); end
    total++;
    if ({match_w[0], code_w[0]} !== e) begin
      bad++; $display("FAIL ign_result: got %h want %h", {match_w[0], code_w[0]}, e);
    end
    total++;
    if (bx !== 1'b0) begin bad++; $display("FAIL ign_start_in_done: got busy=%b want 0", bx); end
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      if (done_w[0] === 1'b1 || busy_w[0] === 1'b1) extra++;
      @(posedge clk);
      #1;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL ign_quiet_after: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid;
    int lat, bn, n, dones;
    logic dn, bx;
    logic [8:0] e;
    gate_sel[0] = 2'd0;
    drive_start(0, 8'hC0, {1'b1, 8'hC0});
    n = 0;
    while ({in1_w[0], in2_w[0], in3_w[0]} !== 3'b100 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++;
    if (n >= 100) begin bad++; $display("FAIL rmid_reach_row4: got timeout want row 100"); end
    void'(exp_q.pop_front());
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in1_w[0], in2_w[0], in3_w[0], busy_w[0], done_w[0], match_w[0], code_w[0]} !== 14'b0) begin
      bad++;
      $display("FAIL rmid_async_clear: got %b want all zero",
               {in1_w[0], in2_w[0], in3_w[0], busy_w[0], done_w[0], match_w[0], code_w[0]});
    end
    dones = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done_w[0] !== 1'b0 || st_w[0] !== 2'd0) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL rmid_no_done: got %0d cycles want 0", dones); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    gate_sel[0] = 2'd3;
    drive_start(0, 8'h69, {1'b1, 8'h69});
    sweep_watch(0, 0, 1'b0, lat, bn, dn, bx);
    e = exp_q.pop_front();
    total++;
    if (lat !== 49 || row_seen[1] !== 3'b000) begin
      bad++; $display("FAIL rmid_fresh_sweep: got lat=%0d row1=%b want 49/000", lat, row_seen[1]);
    end
    total++;
    if ({match_w[0], code_w[0]} !== e) begin
      bad++; $display("FAIL rmid_result: got %h want %h", {match_w[0], code_w[0]}, e);
    end
  endtask

  task automatic test_delay_gate;
    int lat, bn;
    logic dn, bx;
    logic [8:0] e;
    gate_sel[2] = 2'd3;
    repeat (4) @(posedge clk);
    #1;
    drive_start(2, 8'h69, {1'b1, 8'h69});
    sweep_watch(2, 0, 1'b0, lat, bn, dn, bx);
    e = exp_q.pop_front();
    total++;
    if (lat !== 33) begin bad++; $display("FAIL dly_latency: got %0d want 33", lat); end
    total++;
    if ({match_w[2], code_w[2]} !== e) begin
      bad++; $display("FAIL dly_result: got %h want %h", {match_w[2], code_w[2]}, e);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bn;
    logic dn, bx;
    logic [8:0] e;
    gate_sel[1] = 2'd1;
    drive_start(1, 8'h01, {1'b1, 8'h01});
    sweep_watch(1, 0, 1'b0, lat, bn, dn, bx);
    e = exp_q.pop_front();
    total++;
    if ({match_w[1], code_w[1]} !== e) begin
      bad++; $display("FAIL b2b_first: got %h want %h", {match_w[1], code_w[1]}, e);
    end
    gate_sel[1] = 2'd0;
    drive_start(1, 8'hC0, {1'b1, 8'hC0});
    sweep_watch(1, 0, 1'b0, lat, bn, dn, bx);
    e = exp_q.pop_front();
    total++;
    if (lat !== 17) begin bad++; $display("FAIL b2b_latency: got %0d want 17", lat); end
    total++;
    if ({match_seen[1], row_seen[1]} !== 4'b0000) begin
      bad++; $display("FAIL b2b_restart: got match,row=%b want 0000", {match_seen[1], row_seen[1]});
    end
    total++;
    if ({match_w[1], code_w[1]} !== e) begin
      bad++; $display("FAIL b2b_second: got %h want %h", {match_w[1], code_w[1]}, e);
    end
  endtask

  initial begin
    for (int d = 0; d < 3; d++) gate_sel[d] = 2'd0;
    test_reset();
    test_nor();
    test_and3_rows();
    test_const1_s0();
    test_ignore_start();
    test_reset_mid();
    test_delay_gate();
    test_back_to_back();
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
